// File: rtl/dcache_ctrl_if.sv
// Single-outstanding req/ack memory bus between the data cache (master) and memory (slave).
interface dcache_ctrl_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_size;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wstrb, m_size,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_wstrb, m_size,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Cached load hits return in zero cycles; misses, stores and uncached accesses stall.
module dcache_ctrl #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         d_addr,
    input  logic [31:0]         d_wdata,
    input  logic [2:0]          d_size,
    input  logic [1:0]          d_en,
    input  logic [3:0]          w_byte_select,
    output logic [31:0]         d_rdata,
    output logic                d_stall,
    dcache_ctrl_if.master       mem
);
    localparam int TAG_W      = 30 - INDEX_W - OFFSET_W;
    localparam int LINES      = 1 << INDEX_W;
    localparam int LINE_WORDS = 1 << OFFSET_W;

    typedef enum logic [2:0] {IDLE, REFILL, UNC_RD, WRITE, DONE} state_e;

    state_e                     state_q, state_d;
    logic [LINES-1:0]           valid_q, valid_d;
    logic [OFFSET_W-1:0]        cnt_q, cnt_d;
    logic                       m_req_q, m_req_d;
    logic                       m_we_q, m_we_d;
    logic [31:0]                m_addr_q, m_addr_d;
    logic [31:0]                m_wdata_q, m_wdata_d;
    logic [3:0]                 m_wstrb_q, m_wstrb_d;
    logic [2:0]                 m_size_q, m_size_d;
    logic [31:0]                unc_q, unc_d;

    logic [TAG_W-1:0]           tag_q  [LINES];
    logic [LINE_WORDS-1:0][31:0] data_q [LINES];

    logic [INDEX_W-1:0]         idx;
    logic [OFFSET_W-1:0]        off;
    logic [TAG_W-1:0]           tag;
    logic                       access, is_store, uncached, hit, ack, last;

    logic                       tag_we, data_we;
    logic [3:0]                 data_wmask;
    logic [OFFSET_W-1:0]        data_woff;
    logic [31:0]                data_wword;

    assign idx      = d_addr[OFFSET_W+2 +: INDEX_W];
    assign off      = d_addr[2 +: OFFSET_W];
    assign tag      = d_addr[31 -: TAG_W];
    assign access   = (d_en == 2'b01);
    assign is_store = (w_byte_select != 4'b0000);
    assign uncached = (d_addr[31:29] == 3'b101);
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign ack      = mem.m_ack && m_req_q;
    assign last     = (cnt_q == OFFSET_W'(LINE_WORDS - 1));

    assign mem.m_req   = m_req_q;
    assign mem.m_we    = m_we_q;
    assign mem.m_addr  = m_addr_q;
    assign mem.m_wdata = m_wdata_q;
    assign mem.m_wstrb = m_wstrb_q;
    assign mem.m_size  = m_size_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        m_size_d   = m_size_q;
        unc_d      = unc_q;
        d_stall    = 1'b0;
        d_rdata    = 32'h0;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        data_wmask = 4'h0;
        data_woff  = off;
        data_wword = d_wdata;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (is_store) begin
                        d_stall   = 1'b1;
                        state_d   = WRITE;
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b1;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_wstrb_d = w_byte_select;
                        m_size_d  = d_size;
                    end else if (uncached) begin
                        d_stall   = 1'b1;
                        state_d   = UNC_RD;
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b0;
                        m_addr_d  = d_addr;
                        m_wstrb_d = 4'h0;
                        m_size_d  = d_size;
                    end else if (hit) begin
                        d_rdata = data_q[idx][off];
                    end else begin
                        d_stall   = 1'b1;
                        state_d   = REFILL;
                        cnt_d     = '0;
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b0;
                        m_addr_d  = {d_addr[31:OFFSET_W+2], {OFFSET_W{1'b0}}, 2'b00};
                        m_wstrb_d = 4'h0;
                        m_size_d  = 3'b010;
                    end
                end
            end
            REFILL: begin
                d_stall = 1'b1;
                if (ack) begin
                    data_we    = 1'b1;
                    data_wmask = 4'hF;
                    data_woff  = cnt_q;
                    data_wword = mem.m_rdata;
                    cnt_d      = cnt_q + OFFSET_W'(1);
                    if (last) begin
                        m_req_d      = 1'b0;
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        m_addr_d = {d_addr[31:OFFSET_W+2], cnt_q + OFFSET_W'(1), 2'b00};
                    end
                end
            end
            UNC_RD: begin
                d_stall = 1'b1;
                if (ack) begin
                    unc_d   = mem.m_rdata;
                    m_req_d = 1'b0;
                    state_d = DONE;
                end
            end
            WRITE: begin
                d_stall = 1'b1;
                if (ack) begin
                    unc_d   = 32'h0;
                    m_req_d = 1'b0;
                    state_d = DONE;
                    // No allocate: only a resident line absorbs the store.
                    if (!uncached && hit) begin
                        data_we    = 1'b1;
                        data_wmask = w_byte_select;
                    end
                end
            end
            DONE: begin
                d_rdata = unc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            m_wstrb_q <= 4'h0;
            m_size_q  <= 3'b010;
            unc_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            m_size_q  <= m_size_d;
            unc_q     <= unc_d;
        end
    end

    // Tag/data storage carries no reset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_wmask[b]) begin
                    data_q[idx][data_woff][b*8 +: 8] <= data_wword[b*8 +: 8];
                end
            end
        end
    end
endmodule
